// File: rtl/btn_debounce_edge_pkg.sv
// Shared definitions for the push-button conditioner:
// per-channel FSM states and EGO1 default timing.
package btn_debounce_edge_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 10000;
    localparam int DEF_LONG_CYCLES     = 100000000;

endpackage

// File: rtl/btn_debounce_edge_chan.sv
// One button channel: input synchroniser, debounce FSM,
// press/release/long-press pulse generation.
module btn_debounce_edge_chan
    import btn_debounce_edge_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    // Hold must represent LONG_CYCLES itself so it can saturate there.
    localparam int HW = $clog2(LONG_CYCLES + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 1);

    btn_state_e    state_q;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [HW-1:0] hold_q;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;
    logic          raw_d;
    logic          s;
    logic          holding;

    assign raw_d   = raw_i ^ BTN_ACTIVE_LOW;
    assign s       = sync_q[1];
    assign holding = (state_q == PRESSED) ||
                     (state_q == RELEASE_WAIT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], raw_d};
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;

            if (holding && hold_q != HOLD_MAX) begin
                hold_q <= hold_q + HW'(1);
                if (hold_q == HOLD_FIRE) begin
                    long_q <= 1'b1;
                end
            end

            unique case (state_q)
                IDLE: begin
                    if (s) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= CW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        hold_q  <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= CW'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/btn_debounce_edge.sv
// Multi-channel push-button conditioner: N_BTN independent
// debounced channels with press/release/long-press pulses.
module btn_debounce_edge
    import btn_debounce_edge_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic             sys_clk_in,
    input  logic             sys_rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_debounce_edge_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
        ) u_chan (
            .clk_i     (sys_clk_in),
            .rst_i     (sys_rst),
            .raw_i     (btn_raw[g]),
            .level_o   (btn_level[g]),
            .press_o   (btn_press[g]),
            .release_o (btn_release[g]),
            .long_o    (btn_long[g])
        );
    end

endmodule
